// File: rtl/controlador_sequenciador_if.sv
// Control bus between the SAP-1 sequencer and the datapath: run/opcode inputs,
// ring-counter state, control word, halt flag and retired-instruction count.
interface controlador_sequenciador_if #(
    parameter int OP_W  = 4,
    parameter int NUM_T = 6,
    parameter int CNT_W = 8
);
    logic             habilita;
    logic [OP_W-1:0]  opcode;
    logic [NUM_T-1:0] estado_t;
    logic             ciclo_busca;
    logic             ce_n;
    logic             cp;
    logic             ep;
    logic             lm;
    logic             li;
    logic             ei;
    logic             la;
    logic             ea;
    logic             lb;
    logic             su;
    logic             eu;
    logic             lo;
    logic             hlt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  habilita, opcode,
        output estado_t, ciclo_busca, ce_n, cp, ep, lm, li, ei,
               la, ea, lb, su, eu, lo, hlt, instr_cnt
    );

    modport slave (
        output habilita, opcode,
        input  estado_t, ciclo_busca, ce_n, cp, ep, lm, li, ei,
               la, ea, lb, su, eu, lo, hlt, instr_cnt
    );
endinterface

// File: rtl/controlador_sequenciador.sv
// SAP-1 control/sequencing unit: one-hot T1..T6 ring counter, opcode decode into
// the per-state control word, sticky halt and retired-instruction counter.
module controlador_sequenciador #(
    parameter int OP_W  = 4,
    parameter int NUM_T = 6,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    controlador_sequenciador_if.master  bus
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } estado_e;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

    estado_e          r_estado;
    estado_e          w_estado_nxt;
    logic             r_hlt;
    logic             w_hlt_set;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_run;
    logic             w_ciclo_busca;
    logic             w_ce_n;
    logic             w_cp, w_ep, w_lm, w_li, w_ei, w_la, w_ea, w_lb, w_su, w_eu, w_lo;

    // rst_n gates the decode so nothing is driven while reset is held
    assign w_run = rst_n & bus.habilita & ~r_hlt;

    // State, halt and instruction-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= T1;
            r_hlt    <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_estado <= w_estado_nxt;
            r_hlt    <= r_hlt | w_hlt_set;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next state, counter and control word decode
    always_comb begin
        w_estado_nxt  = r_estado;
        w_cnt_nxt     = r_cnt;
        w_hlt_set     = 1'b0;
        w_ce_n        = 1'b1;
        w_cp          = 1'b0;
        w_ep          = 1'b0;
        w_lm          = 1'b0;
        w_li          = 1'b0;
        w_ei          = 1'b0;
        w_la          = 1'b0;
        w_ea          = 1'b0;
        w_lb          = 1'b0;
        w_su          = 1'b0;
        w_eu          = 1'b0;
        w_lo          = 1'b0;

        case (r_estado)
            T1, T2, T3: w_ciclo_busca = 1'b1;
            T4, T5, T6: w_ciclo_busca = 1'b0;
            default:    w_ciclo_busca = 1'b1;
        endcase

        if (w_run) begin
            case (r_estado)
                T1: begin
                    w_ep         = 1'b1;
                    w_lm         = 1'b1;
                    w_estado_nxt = T2;
                end
                T2: begin
                    w_cp         = 1'b1;
                    w_estado_nxt = T3;
                end
                T3: begin
                    w_ce_n       = 1'b0;
                    w_li         = 1'b1;
                    w_estado_nxt = T4;
                end
                T4: begin
                    w_estado_nxt = T5;
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            w_ei = 1'b1;
                            w_lm = 1'b1;
                        end
                        OP_OUT: begin
                            w_ea = 1'b1;
                            w_lo = 1'b1;
                        end
                        OP_HLT: begin
                            w_hlt_set    = 1'b1;
                            w_estado_nxt = T4;
                        end
                        default: w_hlt_set = 1'b0;
                    endcase
                end
                T5: begin
                    w_estado_nxt = T6;
                    case (bus.opcode)
                        OP_LDA: begin
                            w_ce_n = 1'b0;
                            w_la   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            w_ce_n = 1'b0;
                            w_lb   = 1'b1;
                        end
                        default: w_ce_n = 1'b1;
                    endcase
                end
                T6: begin
                    w_estado_nxt = T1;
                    w_cnt_nxt    = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    case (bus.opcode)
                        OP_ADD: begin
                            w_eu = 1'b1;
                            w_la = 1'b1;
                        end
                        OP_SUB: begin
                            w_su = 1'b1;
                            w_eu = 1'b1;
                            w_la = 1'b1;
                        end
                        default: w_eu = 1'b0;
                    endcase
                end
                default: w_estado_nxt = T1;
            endcase
        end else begin
            w_estado_nxt = r_estado;
        end
    end

    assign bus.estado_t    = NUM_T'(r_estado);
    assign bus.ciclo_busca = w_ciclo_busca;
    assign bus.ce_n        = w_ce_n;
    assign bus.cp          = w_cp;
    assign bus.ep          = w_ep;
    assign bus.lm          = w_lm;
    assign bus.li          = w_li;
    assign bus.ei          = w_ei;
    assign bus.la          = w_la;
    assign bus.ea          = w_ea;
    assign bus.lb          = w_lb;
    assign bus.su          = w_su;
    assign bus.eu          = w_eu;
    assign bus.lo          = w_lo;
    // Halt shows up in T4 already, before the sticky bit has been written
    assign bus.hlt         = r_hlt | w_hlt_set;
    assign bus.instr_cnt   = r_cnt;
endmodule

// File: tb/tb_controlador_sequenciador.sv
// Directed bench for the SAP-1 sequencer with a small bus/RAM/register datapath
// model so that whole programs can be executed against it.
module tb_controlador_sequenciador;
    logic clk;
    logic rst_n;

    controlador_sequenciador_if #(.OP_W(4), .NUM_T(6), .CNT_W(8)) cs_if ();

    controlador_sequenciador #(.OP_W(4), .NUM_T(6), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cs_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model
    logic [7:0] ram [0:15];
    logic [3:0] pc, mar;
    logic [7:0] ir, ra, rb, rout;
    logic [7:0] dbus;

    assign cs_if.opcode = ir[7:4];

    always_comb begin
        dbus = 8'h00;
        if (cs_if.ep)        dbus = {4'h0, pc};
        else if (cs_if.ei)   dbus = {4'h0, ir[3:0]};
        else if (cs_if.ea)   dbus = ra;
        else if (cs_if.eu)   dbus = cs_if.su ? (ra - rb) : (ra + rb);
        else if (!cs_if.ce_n) dbus = ram[mar];
        else                 dbus = 8'h00;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= 4'h0; mar <= 4'h0; ir <= 8'h00;
            ra <= 8'h00; rb <= 8'h00; rout <= 8'h00;
        end else begin
            if (cs_if.cp) pc   <= pc + 4'h1;
            if (cs_if.lm) mar  <= dbus[3:0];
            if (cs_if.li) ir   <= dbus;
            if (cs_if.la) ra   <= dbus;
            if (cs_if.lb) rb   <= dbus;
            if (cs_if.lo) rout <= dbus;
        end
    end

    wire [10:0] ctrl = {cs_if.cp, cs_if.ep, cs_if.lm, cs_if.li, cs_if.ei, cs_if.la,
                        cs_if.ea, cs_if.lb, cs_if.su, cs_if.eu, cs_if.lo};

    localparam logic [10:0] C_NONE = 11'b000_0000_0000;
    localparam logic [10:0] C_T1   = 11'b011_0000_0000;
    localparam logic [10:0] C_LI   = 11'b000_1000_0000;
    localparam logic [10:0] C_LB   = 11'b000_0000_1000;

    // Per-cycle invariants: single bus driver, one-hot state, su implies eu
    int inv_viol;
    initial inv_viol = 0;
    always @(negedge clk) begin
        if ((32'(cs_if.ep) + 32'(cs_if.ei) + 32'(cs_if.ea) + 32'(cs_if.eu) + 32'(!cs_if.ce_n)) > 32'd1
            || $countones(cs_if.estado_t) != 1
            || (cs_if.su && !cs_if.eu))
            inv_viol <= inv_viol + 1;
    end

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        cs_if.habilita = 1'b1;
        for (int a = 0; a < 16; a++) ram[a] = 8'h00;
        ram[0] = 8'h0A; ram[1] = 8'h1B; ram[2] = 8'h1C;
        ram[3] = 8'h2D; ram[4] = 8'hE0; ram[5] = 8'hF0;
        ram[10] = 8'd1; ram[11] = 8'd4; ram[12] = 8'd5; ram[13] = 8'd6;

        tick(2);
        chk("rst_estado", 32'(cs_if.estado_t), 32'h01);
        chk("rst_ce_n", 32'(cs_if.ce_n), 32'h1);
        chk("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        chk("rst_cb", 32'(cs_if.ciclo_busca), 32'h1);
        chk("rst_hlt_cnt", {23'd0, cs_if.hlt, cs_if.instr_cnt}, 32'h0);

        // Program: LDA 10; ADD 11; ADD 12; SUB 13; OUT; HLT
        rst_n = 1'b1;
        #1;
        chk("t1_ctrl", 32'(ctrl), 32'(C_T1));
        tick(30);
        chk("prog_out", 32'(rout), 32'd4);
        chk("prog_cnt", 32'(cs_if.instr_cnt), 32'd5);
        chk("prog_t1", 32'(cs_if.estado_t), 32'h01);
        tick(2);
        chk("prog_hlt_c33", 32'(cs_if.hlt), 32'h0);
        tick(1);
        chk("prog_hlt_c34", 32'(cs_if.hlt), 32'h1);
        chk("prog_hlt_ctrl", {20'd0, cs_if.ce_n, ctrl}, {20'd0, 1'b1, C_NONE});

        // Halted: habilita is ignored
        for (int c = 0; c < 20; c++) begin
            cs_if.habilita = c[0];
            tick(1);
        end
        cs_if.habilita = 1'b1;
        #1;
        chk("hlt_estado", 32'(cs_if.estado_t), 32'h08);
        chk("hlt_sticky", 32'(cs_if.hlt), 32'h1);
        chk("hlt_cnt", 32'(cs_if.instr_cnt), 32'd5);
        chk("hlt_ctrl", {20'd0, cs_if.ce_n, ctrl}, {20'd0, 1'b1, C_NONE});

        // Asynchronous reset in T5 of ADD
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(10);
        chk("add_t5_ctrl", {20'd0, cs_if.ce_n, ctrl}, {20'd0, 1'b0, C_LB});
        chk("add_t5_cnt", 32'(cs_if.instr_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_estado", 32'(cs_if.estado_t), 32'h01);
        chk("arst_ctrl", {20'd0, cs_if.ce_n, ctrl}, {20'd0, 1'b1, C_NONE});
        chk("arst_cnt", 32'(cs_if.instr_cnt), 32'd0);
        tick(3);
        chk("arst_hold", {cs_if.estado_t, cs_if.ce_n, ctrl}, {14'd0, 6'h01, 1'b1, C_NONE});
        rst_n = 1'b1;

        // Pause in T3
        tick(2);
        chk("t3_run", {20'd0, cs_if.ce_n, ctrl}, {20'd0, 1'b0, C_LI});
        cs_if.habilita = 1'b0;
        #1;
        chk("pause_now", {20'd0, cs_if.ce_n, ctrl}, {20'd0, 1'b1, C_NONE});
        for (int c = 0; c < 4; c++) begin
            tick(1);
            chk("pause_hold", {cs_if.ciclo_busca, cs_if.estado_t, cs_if.ce_n, ctrl},
                {13'd0, 1'b1, 6'h04, 1'b1, C_NONE});
        end
        cs_if.habilita = 1'b1;
        #1;
        chk("resume", {20'd0, cs_if.ce_n, ctrl}, {20'd0, 1'b0, C_LI});
        tick(1);
        chk("resume_t4", {18'd0, cs_if.estado_t, ir}, {18'd0, 6'h08, 8'h0A});

        // Undefined opcode 0101 executes as NOP
        rst_n = 1'b0;
        for (int a = 0; a < 16; a++) ram[a] = 8'h50;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("nop_t4", {cs_if.estado_t, cs_if.ciclo_busca, cs_if.ce_n, ctrl},
            {14'd0, 6'h08, 1'b0, 1'b1, C_NONE});
        tick(1);
        chk("nop_t5", {cs_if.estado_t, cs_if.ciclo_busca, cs_if.ce_n, ctrl},
            {14'd0, 6'h10, 1'b0, 1'b1, C_NONE});
        tick(1);
        chk("nop_t6", {cs_if.estado_t, cs_if.ciclo_busca, cs_if.ce_n, ctrl},
            {14'd0, 6'h20, 1'b0, 1'b1, C_NONE});
        tick(1);
        chk("nop_cnt", 32'(cs_if.instr_cnt), 32'd1);

        // Counter wrap after 256 instructions
        tick(254 * 6);
        chk("wrap_255", 32'(cs_if.instr_cnt), 32'd255);
        tick(6);
        chk("wrap_0", 32'(cs_if.instr_cnt), 32'd0);
        chk("wrap_hlt", 32'(cs_if.hlt), 32'h0);

        chk("invariants", 32'(inv_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
